// File: rtl/axis_slav_demux.sv
// AXI-Stream 1-to-pNUM_CH slave demux with a 2-entry registered-ready skid buffer,
// a per-packet latched project select, and counting of packets sent to absent projects.
module axis_slav_demux #(
    parameter int pUSER_PROJECT_SIDEBAND_WIDTH = 5,
    parameter int pDATA_WIDTH                  = 32,
    parameter int pNUM_CH                      = 4,
    parameter int pCNT_WIDTH                   = 16
) (
    input  logic                                    axis_clk,
    input  logic                                    axis_rst_n,
    input  logic [4:0]                              user_prj_sel,
    input  logic                                    s_tvalid,
    input  logic [pDATA_WIDTH-1:0]                  s_tdata,
    input  logic [1:0]                              s_tuser,
    input  logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] s_tupsb,
    input  logic [pDATA_WIDTH/8-1:0]                s_tstrb,
    input  logic [pDATA_WIDTH/8-1:0]                s_tkeep,
    input  logic                                    s_tlast,
    output logic                                    s_tready,
    output logic [pNUM_CH-1:0]                      ss_tvalid,
    input  logic [pNUM_CH-1:0]                      ss_tready,
    output logic [pDATA_WIDTH-1:0]                  ss_tdata,
    output logic [1:0]                              ss_tuser,
    output logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] ss_tupsb,
    output logic [pDATA_WIDTH/8-1:0]                ss_tstrb,
    output logic [pDATA_WIDTH/8-1:0]                ss_tkeep,
    output logic                                    ss_tlast,
    output logic                                    pkt_active,
    output logic [pCNT_WIDTH-1:0]                   drop_cnt
);

    localparam int KW = pDATA_WIDTH / 8;
    localparam int EW = pDATA_WIDTH + pUSER_PROJECT_SIDEBAND_WIDTH + 2 * KW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PKT  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [EW-1:0] ent0, ent1, din;
    logic [1:0]    occ, occ_nxt;
    logic [1:0]    state, state_nxt, mode;
    logic [4:0]    lat_sel, cur_sel;
    logic          head_v, head_last, push, pop, wr_hi, drop_done;
    logic          unused_tuser;

    assign unused_tuser = ^s_tuser;

    assign din = {s_tdata, s_tupsb, s_tstrb, s_tkeep, s_tlast};
    assign {ss_tdata, ss_tupsb, ss_tstrb, ss_tkeep, ss_tlast} = ent0;
    assign ss_tuser   = 2'b00;
    assign pkt_active = (state != IDLE);

    assign head_v    = (occ != 2'd0);
    assign head_last = ent0[0];
    assign push      = s_tvalid & s_tready;

    // In IDLE the incoming head already uses the live select, so it is routed in its first cycle.
    always_comb begin
        cur_sel = lat_sel;
        mode    = state;
        if (state == IDLE && head_v) begin
            cur_sel = user_prj_sel;
            mode    = (int'(user_prj_sel) < pNUM_CH) ? PKT : DROP;
        end
    end

    always_comb begin
        ss_tvalid = '0;
        for (int unsigned i = 0; i < pNUM_CH; i++) begin
            ss_tvalid[i] = (mode == PKT) && head_v && (cur_sel == 5'(i));
        end
    end

    assign pop       = (|(ss_tvalid & ss_tready)) | ((mode == DROP) & head_v);
    assign drop_done = (mode == DROP) & pop & head_last;
    assign state_nxt = (pop & head_last) ? IDLE : mode;
    assign occ_nxt   = occ + {1'b0, push} - {1'b0, pop};
    assign wr_hi     = (occ == 2'd2) || (occ == 2'd1 && !pop);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ent0     <= '0;
            ent1     <= '0;
            occ      <= '0;
            s_tready <= 1'b1;
            state    <= IDLE;
            lat_sel  <= '0;
            drop_cnt <= '0;
        end else begin
            occ      <= occ_nxt;
            s_tready <= (occ_nxt != 2'd2);
            state    <= state_nxt;
            if (state == IDLE && head_v)
                lat_sel <= user_prj_sel;
            if (pop)
                ent0 <= ent1;
            // A push lands after the shift, so it overrides the shifted slot when both target ent0.
            if (push) begin
                if (wr_hi)
                    ent1 <= din;
                else
                    ent0 <= din;
            end
            if (drop_done && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_slav_demux.sv
// Self-checking bench for axis_slav_demux: queue model of accepted beats with per-packet
// destination, checked against the demux outputs every cycle, plus literal checks per test.
module tb_axis_slav_demux;

    localparam int NCH = 4;
    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  user_prj_sel;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic [1:0]  s_tuser;
    logic [4:0]  s_tupsb;
    logic [3:0]  s_tstrb;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tready;
    logic [3:0]  ss_tvalid;
    logic [3:0]  ss_tready;
    logic [31:0] ss_tdata;
    logic [1:0]  ss_tuser;
    logic [4:0]  ss_tupsb;
    logic [3:0]  ss_tstrb;
    logic [3:0]  ss_tkeep;
    logic        ss_tlast;
    logic        pkt_active;
    logic [1:0]  drop_cnt;

    axis_slav_demux #(
        .pUSER_PROJECT_SIDEBAND_WIDTH(5),
        .pDATA_WIDTH(32),
        .pNUM_CH(NCH),
        .pCNT_WIDTH(2)
    ) dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .user_prj_sel(user_prj_sel),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tupsb(s_tupsb),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tready(s_tready),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tuser(ss_tuser),
        .ss_tupsb(ss_tupsb), .ss_tstrb(ss_tstrb), .ss_tkeep(ss_tkeep), .ss_tlast(ss_tlast),
        .pkt_active(pkt_active), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        bit          last;
        int          dest;
    } beat_t;

    beat_t       q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          model_drops = 0;
    int          stalls = 0;
    int          n_acc = 0;
    int          del_cnt = 0;
    int          last_ch = -1;
    logic [31:0] last_data = '0;
    bit          last_last = 1'b0;
    bit          chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Beats bound for absent projects never appear downstream; retire them from the model head.
    task automatic skip_drops();
        while (q.size() > 0 && q[0].dest >= NCH) begin
            if (q[0].last) model_drops++;
            void'(q.pop_front());
        end
    endtask

    always begin : compare
        beat_t      e;
        logic [3:0] k;
        @(negedge clk);
        #3;
        if (chk_en) begin
            check("ss_tuser", 64'(ss_tuser), 64'd0);
            check("onehot", 64'($onehot0(ss_tvalid)), 64'd1);
            if (ss_tvalid != 4'b0000) begin
                skip_drops();
                if (q.size() == 0) begin
                    check("phantom_beat", 64'(ss_tvalid), 64'd0);
                end else begin
                    e = q[0];
                    k = ~e.d[3:0];
                    check("route", 64'(ss_tvalid), 64'(32'd1 << e.dest));
                    check("tdata", 64'(ss_tdata), 64'(e.d));
                    check("tlast", 64'(ss_tlast), 64'(e.last));
                    check("tupsb", 64'(ss_tupsb), 64'(e.d[4:0]));
                    check("tstrb", 64'(ss_tstrb), 64'(e.d[3:0]));
                    check("tkeep", 64'(ss_tkeep), 64'(k));
                    if ((ss_tvalid & ss_tready) != 4'b0000) begin
                        void'(q.pop_front());
                        del_cnt++;
                        for (int i = 0; i < NCH; i++)
                            if (ss_tvalid[i]) last_ch = i;
                        last_data = ss_tdata;
                        last_last = ss_tlast;
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input bit last, input int dest);
        int    waitc;
        bit    acc;
        beat_t b;
        waitc    = 0;
        acc      = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tupsb  = d[4:0];
        s_tstrb  = d[3:0];
        s_tkeep  = ~d[3:0];
        s_tlast  = last;
        s_tuser  = 2'b11;
        while (!acc && waitc < 200) begin
            acc = s_tready;
            @(posedge clk);
            if (!acc) begin
                waitc++;
                stalls++;
                @(negedge clk);
            end
        end
        check("accept_wait", 64'(acc), 64'd1);
        if (acc) begin
            b.d = d; b.last = last; b.dest = dest;
            q.push_back(b);
            n_acc++;
        end
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] base, input int n, input int dest);
        for (int i = 0; i < n; i++)
            send_beat(base + 32'(i), (i == n - 1), dest);
    endtask

    task automatic drain();
        ss_tready = 4'b1111;
        repeat (8) @(negedge clk);
        skip_drops();
        check("drain_q_empty", 64'(q.size()), 64'd0);
        check("drain_idle", 64'(pkt_active), 64'd0);
        check("drain_s_tready", 64'(s_tready), 64'd1);
        check("drop_cnt_model", 64'(drop_cnt), 64'((model_drops > CMAX) ? CMAX : model_drops));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n = 1'b0; user_prj_sel = '0; s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0;
        s_tupsb = '0; s_tstrb = '0; s_tkeep = '0; s_tlast = 1'b0; ss_tready = 4'b1111;
        repeat (2) @(negedge clk);
        check("rst_s_tready", 64'(s_tready), 64'd1);
        check("rst_ss_tvalid", 64'(ss_tvalid), 64'd0);
        check("rst_ss_tdata", 64'(ss_tdata), 64'd0);
        check("rst_pkt_active", 64'(pkt_active), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // T1: 4-beat packet to ch2
        user_prj_sel = 5'd2; stalls = 0; del_cnt = 0;
        send_pkt(32'hA0, 4, 2);
        drain();
        check("t1_stalls", 64'(stalls), 64'd0);
        check("t1_count", 64'(del_cnt), 64'd4);
        check("t1_last_data", 64'(last_data), 64'hA3);
        check("t1_last_ch", 64'(last_ch), 64'd2);
        check("t1_last_flag", 64'(last_last), 64'd1);

        // T2: select change mid-packet only affects the next packet
        user_prj_sel = 5'd1;
        send_beat(32'hB0, 1'b0, 1);
        send_beat(32'hB1, 1'b0, 1);
        check("t2_active_mid", 64'(pkt_active), 64'd1);
        user_prj_sel = 5'd3;
        send_beat(32'hB2, 1'b0, 1);
        send_beat(32'hB3, 1'b1, 1);
        send_pkt(32'hD0, 2, 3);
        drain();
        check("t2_last_ch", 64'(last_ch), 64'd3);
        check("t2_last_data", 64'(last_data), 64'hD1);

        // T3: absent project, three packets dropped
        user_prj_sel = 5'd7; stalls = 0;
        send_pkt(32'hE0, 2, 7);
        send_pkt(32'hE8, 1, 7);
        send_pkt(32'hF0, 3, 7);
        drain();
        check("t3_drop_cnt", 64'(drop_cnt), 64'd3);
        check("t3_stalls", 64'(stalls), 64'd0);

        // T4: ch0 back-pressure; other channels' ready must be ignored
        user_prj_sel = 5'd0; del_cnt = 0; n0 = n_acc;
        ss_tready = 4'b1110;
        fork
            send_pkt(32'hC0, 6, 0);
            begin
                repeat (5) @(negedge clk);
                #1;
                check("t4_s_tready_low", 64'(s_tready), 64'd0);
                check("t4_buffered", 64'(n_acc - n0), 64'd2);
                check("t4_hold_data", 64'(ss_tdata), 64'hC0);
                check("t4_hold_valid", 64'(ss_tvalid), 64'b0001);
                check("t4_active", 64'(pkt_active), 64'd1);
                ss_tready[0] = 1'b1;
            end
        join
        drain();
        check("t4_count", 64'(del_cnt), 64'd6);
        check("t4_last_data", 64'(last_data), 64'hC5);

        // T5: asynchronous reset mid-packet
        ss_tready = 4'b0000;
        send_beat(32'h50, 1'b0, 0);
        send_beat(32'h51, 1'b0, 0);
        check("t5_active", 64'(pkt_active), 64'd1);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_s_tready", 64'(s_tready), 64'd1);
        check("t5_ss_tvalid", 64'(ss_tvalid), 64'd0);
        check("t5_ss_tdata", 64'(ss_tdata), 64'd0);
        check("t5_ss_tlast", 64'(ss_tlast), 64'd0);
        check("t5_pkt_active", 64'(pkt_active), 64'd0);
        check("t5_drop_cnt", 64'(drop_cnt), 64'd0);
        q.delete();
        model_drops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        ss_tready = 4'b1111;
        user_prj_sel = 5'd1;
        send_pkt(32'h60, 3, 1);
        drain();
        check("t5_last_ch", 64'(last_ch), 64'd1);
        check("t5_last_data", 64'(last_data), 64'h62);

        // T6: narrow counter saturates
        user_prj_sel = 5'd9;
        for (int i = 0; i < 5; i++)
            send_pkt(32'h70 + 32'(i), 1, 9);
        drain();
        check("t6_drop_sat", 64'(drop_cnt), 64'd3);

        chk_en = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
